// File: rtl/bus_drvr_endpoint_fifo.sv
`default_nettype none
// ============================================================================
// Module  : bus_drvr_endpoint_fifo
// Purpose : Driver-side bus endpoint with a TX FIFO drained by the arbiter and
//           an RX FIFO filled by the bus, plus sticky error flags.
// Revision: 1.0
// ============================================================================
module bus_drvr_endpoint_fifo #(
  parameter int bits  = 32,
  parameter int depth = 8,
  parameter int cw    = $clog2(depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [bits-1:0] wr_data,
  output logic            tx_full,
  output logic [cw-1:0]   tx_count,
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            rd_en,
  output logic [bits-1:0] rd_data,
  output logic            rx_pndng,
  output logic [cw-1:0]   rx_count,
  input  logic            clr_err,
  output logic            tx_drop,
  output logic            rx_drop,
  output logic            pop_err
);

  localparam int          c_aw   = $clog2(depth);
  localparam logic [cw-1:0] c_full = cw'(depth);

  logic [bits-1:0] r_tx_mem [depth];
  logic [bits-1:0] r_rx_mem [depth];
  logic [c_aw-1:0] r_tx_rptr, r_tx_wptr, r_rx_rptr, r_rx_wptr;
  logic [cw-1:0]   r_tx_count, r_rx_count;
  logic            r_tx_drop, r_rx_drop, r_pop_err;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_wr, w_tx_rd, w_rx_wr, w_rx_rd;

  // Full/empty come only from registered counts, so no strobe reaches an output.
  assign w_tx_full  = (r_tx_count == c_full);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == c_full);
  assign w_rx_empty = (r_rx_count == '0);

  assign w_tx_wr = reset & wr_en & ~w_tx_full;
  assign w_tx_rd = reset & pop   & ~w_tx_empty;
  assign w_rx_wr = reset & push  & ~w_rx_full;
  assign w_rx_rd = reset & rd_en & ~w_rx_empty;

  always_ff @(posedge clk) begin
    if (w_tx_wr) r_tx_mem[r_tx_wptr] <= wr_data;
    if (w_rx_wr) r_rx_mem[r_rx_wptr] <= D_push;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_rptr  <= '0;
      r_tx_wptr  <= '0;
      r_tx_count <= '0;
      r_rx_rptr  <= '0;
      r_rx_wptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_tx_wr) r_tx_wptr <= r_tx_wptr + c_aw'(1);
      if (w_tx_rd) r_tx_rptr <= r_tx_rptr + c_aw'(1);
      if (w_rx_wr) r_rx_wptr <= r_rx_wptr + c_aw'(1);
      if (w_rx_rd) r_rx_rptr <= r_rx_rptr + c_aw'(1);
      case ({w_tx_wr, w_tx_rd})
        2'b10:   r_tx_count <= r_tx_count + cw'(1);
        2'b01:   r_tx_count <= r_tx_count - cw'(1);
        default: r_tx_count <= r_tx_count;
      endcase
      case ({w_rx_wr, w_rx_rd})
        2'b10:   r_rx_count <= r_rx_count + cw'(1);
        2'b01:   r_rx_count <= r_rx_count - cw'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // A new error in the same edge as clr_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_drop <= 1'b0;
      r_rx_drop <= 1'b0;
      r_pop_err <= 1'b0;
    end else begin
      r_tx_drop <= (wr_en & w_tx_full) | (r_tx_drop & ~clr_err);
      r_rx_drop <= (push & w_rx_full) | (r_rx_drop & ~clr_err);
      r_pop_err <= (pop & w_tx_empty) | (rd_en & w_rx_empty) | (r_pop_err & ~clr_err);
    end
  end

  assign tx_full  = w_tx_full;
  assign tx_count = r_tx_count;
  assign pndng    = ~w_tx_empty;
  assign D_pop    = r_tx_mem[r_tx_rptr];
  assign rd_data  = r_rx_mem[r_rx_rptr];
  assign rx_pndng = ~w_rx_empty;
  assign rx_count = r_rx_count;
  assign tx_drop  = r_tx_drop;
  assign rx_drop  = r_rx_drop;
  assign pop_err  = r_pop_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_drvr_endpoint_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_drvr_endpoint_fifo
// Purpose : Directed bench for bus_drvr_endpoint_fifo with a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_bus_drvr_endpoint_fifo;

  localparam int c_bits  = 32;
  localparam int c_depth = 8;
  localparam int c_cw    = $clog2(c_depth) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [c_bits-1:0] wr_data = '0, D_push = '0;
  logic tx_full, pndng, rx_pndng, tx_drop, rx_drop, pop_err;
  logic [c_cw-1:0] tx_count, rx_count;
  logic [c_bits-1:0] D_pop, rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  bus_drvr_endpoint_fifo #(.bits(c_bits), .depth(c_depth)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data),
    .rx_pndng(rx_pndng), .rx_count(rx_count), .clr_err(clr_err),
    .tx_drop(tx_drop), .rx_drop(rx_drop), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two queues and three flags updated from the spec rules.
  logic [c_bits-1:0] txq[$];
  logic [c_bits-1:0] rxq[$];
  bit m_tx_drop, m_rx_drop, m_pop_err;
  bit t_full, t_empty, r_full, r_empty;

  always @(posedge clk) begin
    if (!reset) begin
      txq.delete();
      rxq.delete();
      m_tx_drop = 0; m_rx_drop = 0; m_pop_err = 0;
    end else begin
      t_full  = (txq.size() == c_depth);
      t_empty = (txq.size() == 0);
      r_full  = (rxq.size() == c_depth);
      r_empty = (rxq.size() == 0);
      m_tx_drop = (wr_en && t_full) || (m_tx_drop && !clr_err);
      m_rx_drop = (push && r_full) || (m_rx_drop && !clr_err);
      m_pop_err = (pop && t_empty) || (rd_en && r_empty) || (m_pop_err && !clr_err);
      if (pop && !t_empty)   void'(txq.pop_front());
      if (wr_en && !t_full)  txq.push_back(wr_data);
      if (rd_en && !r_empty) void'(rxq.pop_front());
      if (push && !r_full)   rxq.push_back(D_push);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tx_count", 64'(tx_count), 64'(txq.size()));
      chk("m_rx_count", 64'(rx_count), 64'(rxq.size()));
      chk("m_pndng",    64'(pndng),    64'(txq.size() != 0));
      chk("m_rx_pndng", 64'(rx_pndng), 64'(rxq.size() != 0));
      chk("m_tx_full",  64'(tx_full),  64'(txq.size() == c_depth));
      chk("m_tx_drop",  64'(tx_drop),  64'(m_tx_drop));
      chk("m_rx_drop",  64'(rx_drop),  64'(m_rx_drop));
      chk("m_pop_err",  64'(pop_err),  64'(m_pop_err));
      if (txq.size() != 0) chk("m_D_pop",   64'(D_pop),   64'(txq[0]));
      if (rxq.size() != 0) chk("m_rd_data", 64'(rd_data), 64'(rxq[0]));
    end
  end

  // Apply the strobes set by the caller at one edge, then return them to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; pop = 0; push = 0; rd_en = 0; clr_err = 0; reset = 1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_count"}, 64'(tx_count), 64'd0);
    chk({tag, "_rx_count"}, 64'(rx_count), 64'd0);
    chk({tag, "_pndng"},    64'(pndng),    64'd0);
    chk({tag, "_rx_pndng"}, 64'(rx_pndng), 64'd0);
    chk({tag, "_tx_full"},  64'(tx_full),  64'd0);
    chk({tag, "_flags"},    64'({tx_drop, rx_drop, pop_err}), 64'd0);
  endtask

  initial begin
    reset = 0;
    tick();
    tick();
    chk_en = 1;
    chk_reset_state("rst");

    // Four writes then four pops
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 32'hA0 + i;
      tick();
      if (i == 0) begin
        chk("first_pndng", 64'(pndng), 64'd1);
        chk("first_D_pop", 64'(D_pop), 64'hA0);
      end
    end
    chk("tx_count_4", 64'(tx_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("pop_seq", 64'(D_pop), 64'hA0 + 64'(i));
      pop = 1;
      tick();
    end
    chk("pndng_fall", 64'(pndng), 64'd0);
    chk("tx_count_0", 64'(tx_count), 64'd0);

    // Overfill TX
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = 32'hB0 + i;
      tick();
      if (i == 7) chk("tx_full_8", 64'(tx_full), 64'd1);
    end
    chk("tx_drop_9", 64'(tx_drop), 64'd1);
    chk("tx_count_8", 64'(tx_count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_seq", 64'(D_pop), 64'hB0 + 64'(i));
      pop = 1;
      tick();
    end
    chk("ovf_empty", 64'(pndng), 64'd0);
    clr_err = 1;
    tick();
    chk("tx_drop_clr", 64'(tx_drop), 64'd0);

    // Fill RX, then push and read together while full
    for (int i = 1; i <= 8; i++) begin
      push = 1; D_push = 32'(i);
      tick();
    end
    chk("rx_count_8", 64'(rx_count), 64'd8);
    chk("rx_head_1", 64'(rd_data), 64'd1);
    push = 1; D_push = 32'h9; rd_en = 1;
    tick();
    chk("rx_head_2", 64'(rd_data), 64'd2);
    chk("rx_drop_set", 64'(rx_drop), 64'd1);
    chk("rx_count_7", 64'(rx_count), 64'd7);
    for (int i = 2; i <= 8; i++) begin
      chk("rx_seq", 64'(rd_data), 64'(i));
      rd_en = 1;
      tick();
    end
    chk("rx_empty", 64'(rx_pndng), 64'd0);
    clr_err = 1;
    tick();
    chk("rx_drop_clr", 64'(rx_drop), 64'd0);

    // Empty-read errors, and set-wins against clr_err
    pop = 1; rd_en = 1;
    tick();
    chk("pop_err_set", 64'(pop_err), 64'd1);
    chk("err_counts", 64'({tx_count, rx_count}), 64'd0);
    clr_err = 1; pop = 1;
    tick();
    chk("pop_err_setwins", 64'(pop_err), 64'd1);
    clr_err = 1;
    tick();
    chk("pop_err_clr", 64'(pop_err), 64'd0);

    // Streaming write+pop across pointer wrap
    wr_en = 1; wr_data = 32'hC0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("stream_data", 64'(D_pop), 64'hC0 + 64'(i));
      wr_en = 1; wr_data = 32'hC1 + i; pop = 1;
      tick();
      chk("stream_count", 64'(tx_count), 64'd1);
    end
    chk("stream_last", 64'(D_pop), 64'hD4);
    pop = 1;
    tick();

    // Mid-operation reset with strobes active
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 32'hE0 + i;
      if (i < 3) begin push = 1; D_push = 32'hF0 + i; end
      tick();
    end
    chk("pre_rst_counts", 64'({tx_count, rx_count}), 64'({4'd5, 4'd3}));
    reset = 0; pop = 1; push = 1; D_push = 32'h55; wr_en = 1; rd_en = 1;
    tick();
    chk_reset_state("midrst");
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_drvr_endpoint_fifo.md
# bus_drvr_endpoint_fifo

Driver-side endpoint for the parallel bus generator/arbiter, one instance per driver/bus pair. A TX FIFO holds host words until the arbiter pops them: it presents `pndng`/`D_pop` and consumes `pop`. An RX FIFO accepts words the bus pushes (`push`/`D_push`) and holds them until the host reads them. Sticky error flags and occupancy counts support software and scoreboard checks.

## Interface
Parameters:
- `bits`, 32, word width on both host and bus sides.
- `depth`, 8, entries per FIFO; must be a power of two and at least 2.
- `cw`, `$clog2(depth)+1`, count width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `wr_en`  in  1  host write to the TX FIFO.
- `wr_data`  in  bits  host TX word.
- `tx_full`  out  1  TX FIFO holds `depth` words.
- `tx_count`  out  cw  TX occupancy.
- `pndng`  out  1  to the arbiter: TX FIFO is not empty.
- `D_pop`  out  bits  to the arbiter: TX head word (first-word fall-through).
- `pop`  in  1  from the arbiter: consume the TX head.
- `push`  in  1  from the bus: write `D_push` into the RX FIFO.
- `D_push`  in  bits  RX word from the bus.
- `rd_en`  in  1  host consumes the RX head.
- `rd_data`  out  bits  RX head word (first-word fall-through).
- `rx_pndng`  out  1  RX FIFO is not empty.
- `rx_count`  out  cw  RX occupancy.
- `clr_err`  in  1  clears all sticky error flags.
- `tx_drop`  out  1  sticky: a host write arrived while TX was full.
- `rx_drop`  out  1  sticky: a bus push arrived while RX was full.
- `pop_err`  out  1  sticky: `pop` arrived while TX was empty, or `rd_en` arrived while RX was empty.

## Operation
- Each FIFO is a circular buffer with a read pointer, a write pointer and a `cw`-bit count.
  - The pointers are `$clog2(depth)` bits wide and wrap from `depth-1` to 0.
  - `full` is count==depth; `empty` is count==0.
- TX write: `wr_en` with `tx_full`=0 stores `wr_data` and increments the count.
  - `wr_en` with `tx_full`=1 leaves storage unchanged and sets `tx_drop`.
- TX pop: `pop` with TX non-empty advances the read pointer and decrements the count.
  - `pop` with TX empty is ignored and sets `pop_err`.
- TX simultaneous write and pop:
  - When full: the pop proceeds. The write is rejected because `tx_full` was 1 at the edge, so `tx_drop` is set.
  - When empty: the pop is an error and sets `pop_err`. The write proceeds.
  - Otherwise: both proceed and the count is unchanged.
- RX behaves the same way, with `push` as the write and `rd_en` as the read.
  - Drop goes to `rx_drop`; empty-read error goes to `pop_err`.
  - A push and read in the same edge while RX is full: the read proceeds, the push is dropped and `rx_drop` is set.
- `pndng` = !tx_empty and `rx_pndng` = !rx_empty. Both are derived from registered counts, with no combinational path from `pop`, `push`, `wr_en` or `rd_en`.
- `D_pop` = mem_tx[rd_ptr] and `rd_data` = mem_rx[rd_ptr]. When the FIFO is empty these values are don't-care.
- Error flags: a flag sets in the same edge as its event.
  - `clr_err` clears all three flags.
  - If `clr_err` and a new error occur in the same edge, the flag ends set (set wins).

## Timing
- Reset (`reset`=0 at an edge) takes effect at that edge. After it:
  - Pointers and counts are 0.
  - `pndng`=0, `rx_pndng`=0, `tx_full`=0.
  - `tx_count`=0, `rx_count`=0.
  - `tx_drop`=0, `rx_drop`=0, `pop_err`=0.
  - Memory contents are not reset.
- Reset in mid-operation discards all stored words. Any `pop`, `push`, `wr_en` or `rd_en` asserted in the reset edge is ignored.
- Write to visibility takes 1 cycle.
  - `wr_en` at edge N gives `pndng`=1 and `D_pop`=wr_data after edge N.
  - `push` at edge N gives `rx_pndng`=1 and `rd_data`=D_push after edge N.
- After a `pop` at edge N, `D_pop` shows the next word, or `pndng` falls, after edge N.
- Sustained throughput is one write and one read per cycle per FIFO.
- The arbiter may hold `pop` high for a single cycle only per word; every high cycle consumes one word.

## Test plan
- Reset, then `wr_en` words 0xA0..0xA3 on 4 consecutive cycles; pop one per cycle. Expect:
  - `pndng` rises one cycle after the first write.
  - `D_pop` sequence is 0xA0, 0xA1, 0xA2, 0xA3.
  - `pndng` falls after the fourth pop; `tx_count` returns to 0.
- Write 9 words with depth=8. Expect:
  - `tx_full`=1 after the 8th write.
  - `tx_drop`=1 after the 9th write.
  - The popped sequence is the first 8 words only.
  - `clr_err` clears `tx_drop`.
- Push 0x1..0x8 to fill RX, then `push` 0x9 together with `rd_en` in the same cycle. Expect:
  - `rd_data` moves from 0x1 to 0x2.
  - `rx_drop`=1 and `rx_count`=7.
  - 0x9 is never read.
- `pop` while empty, and `rd_en` while empty. Expect `pop_err`=1 and both counts still 0.
- Continuous write and pop every cycle for 20 cycles across pointer wrap-around. Expect:
  - `tx_count` constant at 1.
  - Data returned in order with no loss.
- Fill TX with 5 words and RX with 3, then assert `reset`=0 for one cycle together with `pop` and `push`. Expect all outputs at their reset values in the next cycle.
